// File: rtl/vip_pixel_transform_core.sv
// ---------------------------------------------------------------------------
// vip_pixel_transform_core
//
// Purpose:
//   Pixel processing core for a VIP video stream. It sits between the
//   control-packet decoder and the encoder flow-control wrappers. Each frame
//   uses one transform, chosen when the frame's first beat is accepted:
//   passthrough, greyscale, invert or threshold. Results pass through a
//   two-stage pipeline into an output FIFO that applies backpressure.
//   Decoded control packets are held until an output frame boundary and are
//   then forwarded, so each control packet goes out ahead of its frame.
//
// Parameters:
//   BITS_PER_SYMBOL  - bits per colour symbol
//   SYMBOLS_PER_BEAT - 1 (mono) or 3 (R,G,B with R in the MSBs)
//   FIFO_DEPTH       - output FIFO entries, power of two, >= 4
//   DEFAULT_WIDTH    - value of width_out after reset
//   DEFAULT_HEIGHT   - value of height_out after reset
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall_in, read      - input handshake (beat taken when read & ~stall_in)
//   data_in             - input pixel beat
//   end_of_video        - last beat of the input frame
//   width_in, height_in, interlaced_in, vip_ctrl_valid
//                       - decoded control packet, qualified by a 1-cycle pulse
//   mode, threshold     - transform selection, sampled once per frame
//   stall_out, write    - output handshake (transfer when write & ~stall_out)
//   data_out, end_of_video_out
//                       - output pixel beat and its end-of-frame flag
//   width_out, height_out, interlaced_out
//                       - forwarded control packet
//   vip_ctrl_busy, vip_ctrl_send
//                       - encoder busy input, 1-cycle send pulse
//
// Optional feature (macro FRAME_CHECK_EN):
//   Adds the outputs frame_size_error (sticky) and frame_beat_count [31:0].
//   The core counts output beats in each frame and compares the count with
//   width_out*height_out.
// ---------------------------------------------------------------------------
module vip_pixel_transform_core #(
  parameter int          BITS_PER_SYMBOL  = 8,
  parameter int          SYMBOLS_PER_BEAT = 3,
  parameter int          FIFO_DEPTH       = 16,
  parameter logic [15:0] DEFAULT_WIDTH    = 16'd1920,
  parameter logic [15:0] DEFAULT_HEIGHT   = 16'd1080
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stall_in,
  output logic                                        read,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic                                        end_of_video,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_valid,
  input  logic [1:0]                                  mode,
  input  logic [BITS_PER_SYMBOL-1:0]                  threshold,
  input  logic                                        stall_out,
  output logic                                        write,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  output logic                                        end_of_video_out,
  output logic [15:0]                                 width_out,
  output logic [15:0]                                 height_out,
  output logic [3:0]                                  interlaced_out,
  input  logic                                        vip_ctrl_busy,
  output logic                                        vip_ctrl_send
`ifdef FRAME_CHECK_EN
  ,
  output logic                                        frame_size_error,
  output logic [31:0]                                 frame_beat_count
`endif
);

  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int BW = BITS_PER_SYMBOL;
  localparam int WS = BITS_PER_SYMBOL + 8;   // luma accumulator width
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;                // count reaches FIFO_DEPTH

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GREY = 2'd1,
    MODE_INV  = 2'd2,
    MODE_THR  = 2'd3
  } mode_e;

  // -------------------------------------------------------------------------
  // Input side: frame tracking and mode latch
  // -------------------------------------------------------------------------
  logic          frame_start;   // next accepted beat opens a new frame
  mode_e         frame_mode_q;
  logic [BW-1:0] frame_thr_q;
  mode_e         cur_mode;
  logic [BW-1:0] cur_thr;
  logic          accept;
  logic          ctrl_pending;

  // Pipeline stage registers
  logic          s1_v, s1_eov;
  logic [DW-1:0] s1_data;
  mode_e         s1_mode;
  logic [BW-1:0] s1_thr;
  logic          s2_v, s2_eov;
  logic [DW-1:0] s2_data;
  logic [DW-1:0] s2_next;

  // FIFO state
  logic [DW:0]   mem [FIFO_DEPTH];       // {eov, data}
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          push, pop;
  logic [CW:0]   occupancy;

  // The first beat of a frame uses the live mode and threshold inputs. Later
  // beats of the same frame use the values latched from that first beat.
  assign cur_mode = frame_start ? mode_e'(mode) : frame_mode_q;
  assign cur_thr  = frame_start ? threshold     : frame_thr_q;

  // Beats already in the pipeline count against FIFO space. A beat accepted
  // now can therefore always be written into the FIFO. While a control packet
  // waits for a frame boundary, the first beat of the next frame is held back.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign read      = (occupancy <= (CW+1)'(FIFO_DEPTH - 1)) &&
                     !(ctrl_pending && frame_start);
  assign accept    = read & ~stall_in;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values and block order cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start  <= 1'b1;
      frame_mode_q <= MODE_PASS;
      frame_thr_q  <= '0;
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      if (accept) begin
        frame_start <= end_of_video;
        if (frame_start) begin
          frame_mode_q <= mode_e'(mode);
          frame_thr_q  <= threshold;
        end
      end
    end
  end

  // Datapath payload registers. They are qualified by the valid bits above,
  // so they are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= data_in;
      s1_eov  <= end_of_video;
      s1_mode <= cur_mode;
      s1_thr  <= cur_thr;
    end
    if (s1_v) begin
      s2_data <= s2_next;
      s2_eov  <= s1_eov;
    end
  end

  // -------------------------------------------------------------------------
  // Transform (combinational between S1 and S2)
  // -------------------------------------------------------------------------
  logic [BW-1:0] luma;

  generate
    if (SYMBOLS_PER_BEAT == 3) begin : g_rgb
      logic [WS-1:0] r_w, g_w, b_w, sum;
      assign r_w = WS'(s1_data[3*BW-1 -: BW]);
      assign g_w = WS'(s1_data[2*BW-1 -: BW]);
      assign b_w = WS'(s1_data[BW-1:0]);
      // The weights sum to 256, so the result fits in BITS_PER_SYMBOL+8 bits.
      assign sum  = WS'(77) * r_w + WS'(150) * g_w + WS'(29) * b_w;
      assign luma = sum[WS-1:8];
    end else begin : g_mono
      assign luma = s1_data[BW-1:0];
    end
  endgenerate

  // NOTE: assign a default first so that no path through the case leaves
  // s2_next unassigned, which would infer a latch.
  always_comb begin
    s2_next = s1_data;
    case (s1_mode)
      MODE_PASS: s2_next = s1_data;
      MODE_GREY: s2_next = {SYMBOLS_PER_BEAT{luma}};
      MODE_INV:  s2_next = ~s1_data;
      MODE_THR:  s2_next = (luma >= s1_thr) ? {DW{1'b1}} : {DW{1'b0}};
      default:   s2_next = s1_data;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  assign push = s2_v;
  assign pop  = write & ~stall_out;

  // NOTE: the storage array has no reset. The pointers and count define
  // which entries are valid, and a reset on the array would block RAM
  // inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s2_eov, s2_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The outputs are gated so that they read as zero while the FIFO is empty,
  // including just after reset.
  assign write            = (fifo_count != '0);
  assign data_out         = write ? mem[rd_ptr][DW-1:0] : '0;
  assign end_of_video_out = write & mem[rd_ptr][DW];

  // -------------------------------------------------------------------------
  // Control packet forwarding
  // -------------------------------------------------------------------------
  logic [15:0] pend_width, pend_height;
  logic [3:0]  pend_interlaced;
  logic        release_ok;

  // Release only at a frame boundary: no frame is open at the input and the
  // pipeline and FIFO are empty, so every beat of the previous frame has
  // left the core.
  assign release_ok = ctrl_pending && !vip_ctrl_busy && frame_start &&
                      !s1_v && !s2_v && (fifo_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_pending    <= 1'b0;
      pend_width      <= '0;
      pend_height     <= '0;
      pend_interlaced <= '0;
      vip_ctrl_send   <= 1'b0;
      width_out       <= DEFAULT_WIDTH;
      height_out      <= DEFAULT_HEIGHT;
      interlaced_out  <= '0;
    end else begin
      vip_ctrl_send <= release_ok;
      if (release_ok) begin
        width_out      <= pend_width;
        height_out     <= pend_height;
        interlaced_out <= pend_interlaced;
      end
      // A new packet in the release cycle becomes the next pending packet.
      if (vip_ctrl_valid) begin
        pend_width      <= width_in;
        pend_height     <= height_in;
        pend_interlaced <= interlaced_in;
        ctrl_pending    <= 1'b1;
      end else if (release_ok) begin
        ctrl_pending <= 1'b0;
      end
    end
  end

`ifdef FRAME_CHECK_EN
  // -------------------------------------------------------------------------
  // Output frame size check
  // -------------------------------------------------------------------------
  logic [31:0] beat_cnt;
  logic [31:0] cnt_next;
  logic [31:0] expected_beats;

  assign cnt_next       = beat_cnt + 32'd1;
  assign expected_beats = 32'(width_out) * 32'(height_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt         <= '0;
      frame_beat_count <= '0;
      frame_size_error <= 1'b0;
    end else if (pop) begin
      if (end_of_video_out) begin
        beat_cnt         <= '0;
        frame_beat_count <= cnt_next;
        if (cnt_next != expected_beats) frame_size_error <= 1'b1;
      end else begin
        beat_cnt <= cnt_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vip_pixel_transform_core.sv
// ---------------------------------------------------------------------------
// tb_vip_pixel_transform_core
//
// Directed testbench for vip_pixel_transform_core with the default
// parameters (8-bit RGB, 16-entry FIFO). It covers reset state, pipeline
// latency, each transform, FIFO fill and drain under backpressure, streaming
// throughput, control-packet ordering, per-frame mode latching and reset in
// the middle of a frame. With FRAME_CHECK_EN defined it also covers the
// frame size checker.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vip_pixel_transform_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        read;
  logic [23:0] data_in;
  logic        end_of_video;
  logic [15:0] width_in, height_in;
  logic [3:0]  interlaced_in;
  logic        vip_ctrl_valid;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        stall_out;
  logic        write;
  logic [23:0] data_out;
  logic        end_of_video_out;
  logic [15:0] width_out, height_out;
  logic [3:0]  interlaced_out;
  logic        vip_ctrl_busy;
  logic        vip_ctrl_send;
`ifdef FRAME_CHECK_EN
  logic        frame_size_error;
  logic [31:0] frame_beat_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  vip_pixel_transform_core dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .read             (read),
    .data_in          (data_in),
    .end_of_video     (end_of_video),
    .width_in         (width_in),
    .height_in        (height_in),
    .interlaced_in    (interlaced_in),
    .vip_ctrl_valid   (vip_ctrl_valid),
    .mode             (mode),
    .threshold        (threshold),
    .stall_out        (stall_out),
    .write            (write),
    .data_out         (data_out),
    .end_of_video_out (end_of_video_out),
    .width_out        (width_out),
    .height_out       (height_out),
    .interlaced_out   (interlaced_out),
    .vip_ctrl_busy    (vip_ctrl_busy),
    .vip_ctrl_send    (vip_ctrl_send)
`ifdef FRAME_CHECK_EN
    ,
    .frame_size_error (frame_size_error),
    .frame_beat_count (frame_beat_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the core accepts it.
  task automatic send_beat(input string tag, input logic [23:0] d,
                           input logic e);
    bit ok;
    ok           = 1'b0;
    data_in      = d;
    end_of_video = e;
    stall_in     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    stall_in = 1'b1;
    check({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  // Wait for the next output beat, check it, then let it transfer.
  task automatic expect_out(input string tag, input logic [23:0] d,
                            input logic e);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_valid"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_data"}, 32'(data_out), 32'(d));
      check({tag, "_eov"}, 32'(end_of_video_out), 32'(e));
      stall_out = 1'b0;
      tick();
      stall_out = 1'b1;
    end
  endtask

  initial begin
    int          acc;
    int          sent;
    int          recv;
    logic [23:0] exp_d;

    rst            = 1'b1;
    stall_in       = 1'b1;
    data_in        = '0;
    end_of_video   = 1'b0;
    width_in       = '0;
    height_in      = '0;
    interlaced_in  = '0;
    vip_ctrl_valid = 1'b0;
    mode           = 2'd0;
    threshold      = '0;
    stall_out      = 1'b1;
    vip_ctrl_busy  = 1'b0;

    // ---- Reset state ----
    tick();
    tick();
    check("rst_write", 32'(write), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_eov", 32'(end_of_video_out), 32'd0);
    check("rst_send", 32'(vip_ctrl_send), 32'd0);
    check("rst_width", 32'(width_out), 32'd1920);
    check("rst_height", 32'(height_out), 32'd1080);
    check("rst_interlaced", 32'(interlaced_out), 32'd0);
    check("rst_read", 32'(read), 32'd1);
    rst = 1'b0;

    // ---- Greyscale red, exact 3-cycle latency ----
    mode         = 2'd1;
    stall_out    = 1'b0;
    data_in      = 24'hFF0000;
    end_of_video = 1'b1;
    stall_in     = 1'b0;
    check("lat_read", 32'(read), 32'd1);
    tick();
    stall_in = 1'b1;
    check("lat_c1", 32'(write), 32'd0);
    tick();
    check("lat_c2", 32'(write), 32'd0);
    tick();
    check("lat_c3", 32'(write), 32'd1);
    check("grey_red", 32'(data_out), 32'h4C4C4C);
    check("grey_red_eov", 32'(end_of_video_out), 32'd1);
    tick();
    check("lat_popped", 32'(write), 32'd0);
    stall_out = 1'b1;

    // ---- Threshold at and just below the level ----
    mode      = 2'd3;
    threshold = 8'h80;
    send_beat("thr_in0", 24'h808080, 1'b0);
    send_beat("thr_in1", 24'h7F7F7F, 1'b1);
    expect_out("thr_at", 24'hFFFFFF, 1'b0);
    expect_out("thr_below", 24'h000000, 1'b1);

    // ---- Backpressure: offer 20 beats while the output is stalled ----
    mode     = 2'd0;
    acc      = 0;
    stall_in = 1'b0;
    for (int c = 0; c < 30; c++) begin
      data_in      = 24'hA00000 | 24'(acc);
      end_of_video = (acc == 19);
      if (read && acc < 20) acc++;
      tick();
    end
    stall_in = 1'b1;
    check("bp_accepted", 32'(acc), 32'd16);
    check("bp_read_low", 32'(read), 32'd0);
    for (int i = 0; i < 16; i++) expect_out("bp_out", 24'hA00000 | 24'(i), 1'b0);
    for (int i = 16; i < 20; i++) send_beat("bp_rest_in", 24'hA00000 | 24'(i), i == 19);
    for (int i = 16; i < 20; i++) expect_out("bp_rest", 24'hA00000 | 24'(i), i == 19);

    // ---- Streaming invert at 1 beat/cycle ----
    mode      = 2'd2;
    stall_out = 1'b0;
    sent      = 0;
    recv      = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 8) check("stream_rate", 32'(sent), 32'd8);
      if (write) begin
        exp_d = ~(24'h300000 | 24'(recv));
        check("stream_data", 32'(data_out), 32'(exp_d));
        recv++;
      end
      if (sent < 8) begin
        stall_in     = 1'b0;
        data_in      = 24'h300000 | 24'(sent);
        end_of_video = (sent == 7);
        if (read) sent++;
      end else begin
        stall_in = 1'b1;
      end
      tick();
    end
    stall_in  = 1'b1;
    stall_out = 1'b1;
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_recv", 32'(recv), 32'd8);

    // ---- Control packet mid-frame, encoder busy, latest packet wins ----
    mode          = 2'd0;
    vip_ctrl_busy = 1'b1;
    send_beat("ctrl_a_in", 24'h111111, 1'b0);
    vip_ctrl_valid = 1'b1;
    width_in       = 16'd320;
    height_in      = 16'd240;
    interlaced_in  = 4'd1;
    tick();
    width_in      = 16'd640;
    height_in     = 16'd480;
    interlaced_in = 4'd3;
    tick();
    vip_ctrl_valid = 1'b0;
    check("ctrl_hold_width", 32'(width_out), 32'd1920);
    send_beat("ctrl_b_in", 24'h222222, 1'b1);
    data_in      = 24'h333333;
    end_of_video = 1'b1;
    stall_in     = 1'b0;
    check("ctrl_next_blocked", 32'(read), 32'd0);
    tick();
    stall_in = 1'b1;
    expect_out("ctrl_a", 24'h111111, 1'b0);
    check("ctrl_no_send_mid", 32'(vip_ctrl_send), 32'd0);
    expect_out("ctrl_b", 24'h222222, 1'b1);
    tick();
    tick();
    check("ctrl_busy_no_send", 32'(vip_ctrl_send), 32'd0);
    check("ctrl_busy_read", 32'(read), 32'd0);
    vip_ctrl_busy = 1'b0;
    tick();
    check("ctrl_send", 32'(vip_ctrl_send), 32'd1);
    check("ctrl_width", 32'(width_out), 32'd640);
    check("ctrl_height", 32'(height_out), 32'd480);
    check("ctrl_interlaced", 32'(interlaced_out), 32'd3);
    tick();
    check("ctrl_send_pulse", 32'(vip_ctrl_send), 32'd0);
    check("ctrl_read_open", 32'(read), 32'd1);
    send_beat("ctrl_c_in", 24'h333333, 1'b1);
    expect_out("ctrl_c", 24'h333333, 1'b1);

    // ---- Mode change mid-frame applies only to the next frame ----
    mode = 2'd1;
    send_beat("mchg_in0", 24'hFF0000, 1'b0);
    mode = 2'd2;
    send_beat("mchg_in1", 24'h00FF00, 1'b0);
    send_beat("mchg_in2", 24'h0000FF, 1'b1);
    send_beat("mchg_in3", 24'h123456, 1'b1);
    expect_out("mchg_grey_r", 24'h4C4C4C, 1'b0);
    expect_out("mchg_grey_g", 24'h959595, 1'b0);
    expect_out("mchg_grey_b", 24'h1C1C1C, 1'b1);
    expect_out("mchg_inv", 24'hEDCBA9, 1'b1);

    // ---- Reset mid-frame discards in-flight beats ----
    mode = 2'd0;
    send_beat("mrst_in0", 24'h444444, 1'b0);
    send_beat("mrst_in1", 24'h555555, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_write", 32'(write), 32'd0);
    check("mrst_width", 32'(width_out), 32'd1920);
    check("mrst_read", 32'(read), 32'd1);
    tick();
    tick();
    tick();
    check("mrst_flushed", 32'(write), 32'd0);
    check("mrst_no_eov", 32'(end_of_video_out), 32'd0);
    mode = 2'd2;
    send_beat("mrst_new_in", 24'h0F0F0F, 1'b1);
    expect_out("mrst_new", 24'hF0F0F0, 1'b1);

`ifdef FRAME_CHECK_EN
    // ---- Frame size check: 4x2 announced, 7 beats sent ----
    vip_ctrl_valid = 1'b1;
    width_in       = 16'd4;
    height_in      = 16'd2;
    interlaced_in  = 4'd0;
    tick();
    vip_ctrl_valid = 1'b0;
    tick();
    tick();
    check("fc_width", 32'(width_out), 32'd4);
    mode = 2'd0;
    for (int i = 0; i < 7; i++) send_beat("fc_in", 24'h000100 | 24'(i), i == 6);
    for (int i = 0; i < 7; i++) expect_out("fc_out", 24'h000100 | 24'(i), i == 6);
    check("fc_error", 32'(frame_size_error), 32'd1);
    check("fc_count", frame_beat_count, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("fc_error_cleared", 32'(frame_size_error), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
